frame_buf_sched: RTL and testbench

- Triple-buffer frame scheduler between the VS capture stage and the frame-store DMA engines (write: camera to DDR; read: DDR to detection/display).
- Provides the capture stage's ready input.
- On each accepted frame-start pulse, assigns the write DMA a buffer that is neither being read nor holds the newest complete frame.
- On each read frame-start, locks the read DMA onto the newest complete frame.

---
 rtl/frame_buf_sched.sv | 148 ++++++++++++++
 tb/tb_frame_buf_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buf_sched.sv
`default_nettype none
// ============================================================================
// Module      : frame_buf_sched
// Description : Triple/quad frame-buffer scheduler between the capture stage
//               and the write/read frame-store DMA engines. The optional
//               FRAME_BUF_DROP_CNT_EN macro adds saturating drop counters.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_buf_sched #(
  parameter int unsigned       BUF_NUM     = 3,
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter logic [ADDR_W-1:0] FRAME_BYTES = 32'h0020_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              wr_fs_i,
  input  logic              wr_done_i,
  input  logic              rd_fs_i,
  input  logic              rd_done_i,
  output logic              s_rdy_o,
  output logic              wr_start_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [1:0]        wr_idx_o,
  output logic              rd_start_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [1:0]        rd_idx_o,
  output logic              rd_valid_o
`ifdef FRAME_BUF_DROP_CNT_EN
  ,
  output logic [15:0]       wr_drop_cnt_o,
  output logic [15:0]       rd_drop_cnt_o
`endif
);

  typedef enum logic {W_IDLE = 1'b0, W_ACTIVE = 1'b1} wr_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_ACTIVE = 1'b1} rd_state_t;

  wr_state_t   r_wr_state, w_wr_state_nxt;
  rd_state_t   r_rd_state, w_rd_state_nxt;
  logic [1:0]  r_latest;
  logic [1:0]  w_wr_next;
  logic        w_wr_accept;
  logic        w_rd_accept;
  logic        w_wr_publish;

  function automatic logic [ADDR_W-1:0] buf_addr(input logic [1:0] idx);
    return BASE_ADDR + ADDR_W'(idx) * FRAME_BYTES;
  endfunction

  assign w_wr_accept  = wr_fs_i & s_rdy_o & (r_wr_state == W_IDLE);
  assign w_rd_accept  = rd_fs_i & en_i & rd_valid_o & (r_rd_state == R_IDLE);
  assign w_wr_publish = wr_done_i & (r_wr_state == W_ACTIVE);

  // A read starting this cycle locks r_latest, so it is excluded just like an active read.
  always_comb begin : p_wr_sel
    logic [1:0] cand;
    logic       found;
    logic [1:0] lock_idx;
    logic       lock_vld;
    w_wr_next = wr_idx_o;
    found     = 1'b0;
    lock_vld  = w_rd_accept | (r_rd_state == R_ACTIVE);
    lock_idx  = w_rd_accept ? r_latest : rd_idx_o;
    for (int unsigned k = 1; k < BUF_NUM; k++) begin
      cand = 2'((32'(wr_idx_o) + k) % BUF_NUM);
      if (!found && !(lock_vld && cand == lock_idx) && !(rd_valid_o && cand == r_latest)) begin
        w_wr_next = cand;
        found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_state <= W_IDLE;
      r_rd_state <= R_IDLE;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_rd_state <= w_rd_state_nxt;
    end
  end

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_rd_state_nxt = r_rd_state;
    case (r_wr_state)
      W_IDLE:   if (w_wr_accept) w_wr_state_nxt = W_ACTIVE;
      W_ACTIVE: if (wr_done_i)   w_wr_state_nxt = W_IDLE;
      default:  w_wr_state_nxt = W_IDLE;
    endcase
    case (r_rd_state)
      R_IDLE:   if (w_rd_accept) w_rd_state_nxt = R_ACTIVE;
      R_ACTIVE: if (rd_done_i)   w_rd_state_nxt = R_IDLE;
      default:  w_rd_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s_rdy_o    <= 1'b0;
      wr_start_o <= 1'b0;
      wr_idx_o   <= 2'd0;
      wr_addr_o  <= BASE_ADDR;
      rd_start_o <= 1'b0;
      rd_idx_o   <= 2'd0;
      rd_addr_o  <= BASE_ADDR;
      rd_valid_o <= 1'b0;
      r_latest   <= 2'd0;
    end else begin
      s_rdy_o    <= en_i & (r_wr_state == W_IDLE);
      wr_start_o <= w_wr_accept;
      rd_start_o <= w_rd_accept;
      if (w_wr_accept) begin
        wr_idx_o  <= w_wr_next;
        wr_addr_o <= buf_addr(w_wr_next);
      end
      if (w_wr_publish) begin
        r_latest   <= wr_idx_o;
        rd_valid_o <= 1'b1;
      end
      // Uses the pre-publish r_latest when a write completes in the same cycle.
      if (w_rd_accept) begin
        rd_idx_o  <= r_latest;
        rd_addr_o <= buf_addr(r_latest);
      end
    end
  end

`ifdef FRAME_BUF_DROP_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_drop_cnt_o <= 16'd0;
      rd_drop_cnt_o <= 16'd0;
    end else begin
      if (wr_fs_i && !s_rdy_o && wr_drop_cnt_o != 16'hFFFF)
        wr_drop_cnt_o <= wr_drop_cnt_o + 16'd1;
      if (rd_fs_i && !w_rd_accept && rd_drop_cnt_o != 16'hFFFF)
        rd_drop_cnt_o <= rd_drop_cnt_o + 16'd1;
    end
  end
`else
  // Drop counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_buf_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_buf_sched
// Description : Self-checking bench for frame_buf_sched (vector table plus
//               start-pulse scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_buf_sched;

  localparam logic [31:0] C_BASE = 32'h1000_0000;
  localparam logic [31:0] C_FB   = 32'h0020_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b1;
  logic        wr_fs_i = 1'b0;
  logic        wr_done_i = 1'b0;
  logic        rd_fs_i = 1'b0;
  logic        rd_done_i = 1'b0;
  logic        s_rdy_o;
  logic        wr_start_o;
  logic [31:0] wr_addr_o;
  logic [1:0]  wr_idx_o;
  logic        rd_start_o;
  logic [31:0] rd_addr_o;
  logic [1:0]  rd_idx_o;
  logic        rd_valid_o;
`ifdef FRAME_BUF_DROP_CNT_EN
  logic [15:0] wr_drop_cnt_o;
  logic [15:0] rd_drop_cnt_o;
`endif

  frame_buf_sched dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .wr_fs_i    (wr_fs_i),
    .wr_done_i  (wr_done_i),
    .rd_fs_i    (rd_fs_i),
    .rd_done_i  (rd_done_i),
    .s_rdy_o    (s_rdy_o),
    .wr_start_o (wr_start_o),
    .wr_addr_o  (wr_addr_o),
    .wr_idx_o   (wr_idx_o),
    .rd_start_o (rd_start_o),
    .rd_addr_o  (rd_addr_o),
    .rd_idx_o   (rd_idx_o),
    .rd_valid_o (rd_valid_o)
`ifdef FRAME_BUF_DROP_CNT_EN
    ,
    .wr_drop_cnt_o (wr_drop_cnt_o),
    .rd_drop_cnt_o (rd_drop_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int idx);
    return C_BASE + 32'(idx) * C_FB;
  endfunction

  typedef struct {int idx; int due;} sb_t;
  sb_t wr_q[$];
  sb_t rd_q[$];

  // Every start pulse must match the oldest expectation: index, address and cycle.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (wr_start_o) begin
        if (wr_q.size() == 0) check("wr_start_unexpected", 32'd1, 32'd0);
        else begin
          sb_t e;
          e = wr_q.pop_front();
          check("wr_start_cycle", cyc, e.due);
          check("wr_idx", 32'(wr_idx_o), e.idx);
          check("wr_addr", wr_addr_o, exp_addr(e.idx));
        end
      end
      if (rd_start_o) begin
        if (rd_q.size() == 0) check("rd_start_unexpected", 32'd1, 32'd0);
        else begin
          sb_t e;
          e = rd_q.pop_front();
          check("rd_start_cycle", cyc, e.due);
          check("rd_idx", 32'(rd_idx_o), e.idx);
          check("rd_addr", rd_addr_o, exp_addr(e.idx));
        end
      end
    end
  end

  typedef enum int {
    OP_WR_FS, OP_WR_DONE, OP_RD_FS, OP_RD_DONE, OP_BOTH_FS, OP_DONE_RDFS,
    OP_EN_OFF, OP_EN_ON, OP_CHK_DROP, OP_RST
  } op_e;

  typedef struct {op_e op; int ew; int er; logic ev;} vec_t;
  vec_t tbl[41];

  task automatic reset_checks();
    check("rst_wr_idx", 32'(wr_idx_o), 32'd0);
    check("rst_rd_idx", 32'(rd_idx_o), 32'd0);
    check("rst_rd_valid", 32'(rd_valid_o), 32'd0);
    check("rst_s_rdy", 32'(s_rdy_o), 32'd0);
    check("rst_wr_start", 32'(wr_start_o), 32'd0);
    check("rst_rd_start", 32'(rd_start_o), 32'd0);
    check("rst_wr_addr", wr_addr_o, C_BASE);
    check("rst_rd_addr", rd_addr_o, C_BASE);
`ifdef FRAME_BUF_DROP_CNT_EN
    check("rst_wr_drop", 32'(wr_drop_cnt_o), 32'd0);
    check("rst_rd_drop", 32'(rd_drop_cnt_o), 32'd0);
`endif
  endtask

  task automatic apply(input int row, input vec_t v);
    @(posedge clk_i); #1;
    case (v.op)
      OP_WR_FS:     wr_fs_i = 1'b1;
      OP_WR_DONE:   wr_done_i = 1'b1;
      OP_RD_FS:     rd_fs_i = 1'b1;
      OP_RD_DONE:   rd_done_i = 1'b1;
      OP_BOTH_FS:   begin wr_fs_i = 1'b1; rd_fs_i = 1'b1; end
      OP_DONE_RDFS: begin wr_done_i = 1'b1; rd_fs_i = 1'b1; end
      OP_EN_OFF:    en_i = 1'b0;
      OP_EN_ON:     en_i = 1'b1;
      OP_CHK_DROP: begin
`ifdef FRAME_BUF_DROP_CNT_EN
        check("wr_drop_cnt", 32'(wr_drop_cnt_o), 32'd2);
        check("rd_drop_cnt", 32'(rd_drop_cnt_o), 32'd3);
`endif
      end
      OP_RST: begin
        // Mid-cycle assertion while both DMAs are active.
        @(negedge clk_i); #2;
        rst_i = 1'b1;
        #1 reset_checks();
        @(negedge clk_i);
        rst_i = 1'b0;
      end
      default: ;
    endcase
    if (v.ew >= 0) wr_q.push_back('{v.ew, cyc + 1});
    if (v.er >= 0) rd_q.push_back('{v.er, cyc + 1});
    @(posedge clk_i); #1;
    wr_fs_i = 1'b0; wr_done_i = 1'b0; rd_fs_i = 1'b0; rd_done_i = 1'b0;
    repeat ((v.op == OP_WR_FS) ? 100 : 20) @(posedge clk_i);
    #1;
    check($sformatf("row%0d_rd_valid", row), 32'(rd_valid_o), 32'(v.ev));
    check($sformatf("row%0d_wr_pending", row), wr_q.size(), 32'd0);
    check($sformatf("row%0d_rd_pending", row), rd_q.size(), 32'd0);
    if (v.op == OP_EN_OFF) check("en_off_s_rdy", 32'(s_rdy_o), 32'd0);
    wr_q.delete();
    rd_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl = '{
      '{OP_RD_FS,     -1, -1, 1'b0},  // no frame published: dropped
      '{OP_WR_FS,      1, -1, 1'b0},
      '{OP_WR_DONE,   -1, -1, 1'b1},
      '{OP_WR_FS,      2, -1, 1'b1},
      '{OP_WR_DONE,   -1, -1, 1'b1},
      '{OP_WR_FS,      0, -1, 1'b1},
      '{OP_WR_DONE,   -1, -1, 1'b1},
      '{OP_WR_FS,      1, -1, 1'b1},
      '{OP_WR_DONE,   -1, -1, 1'b1},
      '{OP_RD_FS,     -1,  1, 1'b1},  // read locks 1
      '{OP_WR_FS,      2, -1, 1'b1},
      '{OP_WR_DONE,   -1, -1, 1'b1},
      '{OP_WR_FS,      0, -1, 1'b1},  // avoids read 1 and latest 2
      '{OP_WR_DONE,   -1, -1, 1'b1},
      '{OP_RD_DONE,   -1, -1, 1'b1},
      '{OP_WR_FS,      1, -1, 1'b1},
      '{OP_WR_DONE,   -1, -1, 1'b1},
      '{OP_WR_FS,      2, -1, 1'b1},
      '{OP_WR_DONE,   -1, -1, 1'b1},
      '{OP_BOTH_FS,    0,  2, 1'b1},  // same-cycle starts, latest 2
      '{OP_WR_DONE,   -1, -1, 1'b1},
      '{OP_RD_DONE,   -1, -1, 1'b1},
      '{OP_WR_FS,      1, -1, 1'b1},
      '{OP_DONE_RDFS, -1,  0, 1'b1},  // read gets previous latest
      '{OP_WR_FS,      2, -1, 1'b1},
      '{OP_WR_FS,     -1, -1, 1'b1},  // while write active: dropped
      '{OP_RD_FS,     -1, -1, 1'b1},  // while read active: dropped
      '{OP_WR_DONE,   -1, -1, 1'b1},
      '{OP_RD_DONE,   -1, -1, 1'b1},
      '{OP_EN_OFF,    -1, -1, 1'b1},
      '{OP_WR_FS,     -1, -1, 1'b1},
      '{OP_RD_FS,     -1, -1, 1'b1},
      '{OP_EN_ON,     -1, -1, 1'b1},
      '{OP_CHK_DROP,  -1, -1, 1'b1},
      '{OP_WR_FS,      0, -1, 1'b1},
      '{OP_RD_FS,     -1,  2, 1'b1},
      '{OP_RST,       -1, -1, 1'b0},
      '{OP_WR_FS,      1, -1, 1'b0},  // reset state: wr_idx 0 -> 1
      '{OP_RD_FS,     -1, -1, 1'b0},
      '{OP_WR_DONE,   -1, -1, 1'b1},
      '{OP_RD_FS,     -1,  1, 1'b1}
    };

    repeat (3) @(posedge clk_i);
    #1 reset_checks();
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 check("s_rdy_after_reset", 32'(s_rdy_o), 32'd1);

    for (int i = 0; i < 41; i++) apply(i, tbl[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
